// File: rtl/rv32_instr_encoder.sv
// Two-stage encoder: decoded RV32I/Zicsr fields -> 32-bit machine word, with a
// sequential imem write address and a saturating count of rejected words.
module rv32_instr_encoder #(
    parameter int XPR_LEN   = 32,
    parameter int IMEM_AW   = 10,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [5:0]           in_opcode,
    input  logic [XPR_LEN-1:0]   in_imm,
    input  logic [12:0]          in_csr,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [4:0]           in_rd,
    input  logic                 addr_clr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XPR_LEN-1:0]   out_instr,
    output logic [5:0]           out_type,
    output logic                 out_err,
    output logic [IMEM_AW-1:0]   out_addr,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    // Opcode enum order mirrors the decoder's rv32_opcode_enum_t.
    typedef enum logic [5:0] {
        OP_LB = 6'h00, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_SLL, OP_SLLI, OP_SRL, OP_SRLI, OP_SRA, OP_SRAI,
        OP_ADD, OP_ADDI, OP_SUB, OP_LUI, OP_AUIPC,
        OP_XOR, OP_XORI, OP_OR, OP_ORI, OP_AND, OP_ANDI,
        OP_SLT, OP_SLTI, OP_SLTU, OP_SLTIU,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_JAL, OP_JALR, OP_FENCE, OP_FENCEI,
        OP_CSRRW, OP_CSRRS, OP_CSRRC, OP_CSRRWI, OP_CSRRSI, OP_CSRRCI,
        OP_ECALL, OP_EBREAK, OP_ERET, OP_MRET, OP_WFI, OP_NOP,
        OP_UNKNOWN = 6'h3F
    } op_e;

    localparam logic [5:0] T_R   = 6'b100000;
    localparam logic [5:0] T_I   = 6'b010000;
    localparam logic [5:0] T_S   = 6'b001000;
    localparam logic [5:0] T_B   = 6'b000100;
    localparam logic [5:0] T_U   = 6'b000010;
    localparam logic [5:0] T_J   = 6'b000001;
    localparam logic [5:0] T_NOP = 6'b000000;
    localparam logic [5:0] T_BAD = 6'b111111;

    localparam logic [6:0] MAJ_LOAD   = 7'b0000011;
    localparam logic [6:0] MAJ_STORE  = 7'b0100011;
    localparam logic [6:0] MAJ_OP     = 7'b0110011;
    localparam logic [6:0] MAJ_OPIMM  = 7'b0010011;
    localparam logic [6:0] MAJ_LUI    = 7'b0110111;
    localparam logic [6:0] MAJ_AUIPC  = 7'b0010111;
    localparam logic [6:0] MAJ_BRANCH = 7'b1100011;
    localparam logic [6:0] MAJ_JAL    = 7'b1101111;
    localparam logic [6:0] MAJ_JALR   = 7'b1100111;
    localparam logic [6:0] MAJ_SYSTEM = 7'b1110011;

    logic                 s1_valid_q, s1_valid_d;
    logic [5:0]           s1_opcode_q, s1_opcode_d;
    logic [XPR_LEN-1:0]   s1_imm_q, s1_imm_d;
    logic [12:0]          s1_csr_q, s1_csr_d;
    logic [4:0]           s1_rs1_q, s1_rs1_d;
    logic [4:0]           s1_rs2_q, s1_rs2_d;
    logic [4:0]           s1_rd_q, s1_rd_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [XPR_LEN-1:0]   s2_instr_q, s2_instr_d;
    logic [5:0]           s2_type_q, s2_type_d;
    logic                 s2_err_q, s2_err_d;
    logic [IMEM_AW-1:0]   addr_q, addr_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Handshake: a word moves across a port on any rising edge where valid and
    // ready are both high; valid, once raised, holds with its data until then.
    logic s2_adv;
    logic out_hs;

    assign s2_adv    = !s2_valid_q || out_ready;
    assign in_ready  = !s1_valid_q || s2_adv;
    assign out_hs    = s2_valid_q && out_ready;
    assign out_valid = s2_valid_q;
    assign out_instr = s2_instr_q;
    assign out_type  = s2_type_q;
    assign out_err   = s2_err_q;
    assign out_addr  = addr_q;
    assign err_cnt   = err_cnt_q;

    logic fits_i, fits_b, fits_j, u_ok, shamt_ok, csr_ok;

    assign fits_i   = (&s1_imm_q[31:11]) || !(|s1_imm_q[31:11]);
    assign fits_b   = ((&s1_imm_q[31:12]) || !(|s1_imm_q[31:12])) && !s1_imm_q[0];
    assign fits_j   = ((&s1_imm_q[31:20]) || !(|s1_imm_q[31:20])) && !s1_imm_q[0];
    assign u_ok     = !(|s1_imm_q[11:0]);
    assign shamt_ok = !(|s1_imm_q[31:5]);
    assign csr_ok   = !s1_csr_q[12];

    logic [5:0]         fmt;
    logic [2:0]         f3;
    logic [6:0]         f7;
    logic [6:0]         maj;
    logic [11:0]        i_field;
    logic               is_fixed, is_shift, is_csr, illegal, range_bad;
    logic [XPR_LEN-1:0] fixed_word, word;

    always_comb begin
        fmt        = T_I;
        f3         = 3'b000;
        f7         = 7'b0000000;
        maj        = MAJ_OPIMM;
        is_fixed   = 1'b0;
        is_shift   = 1'b0;
        is_csr     = 1'b0;
        illegal    = 1'b0;
        fixed_word = '0;
        case (op_e'(s1_opcode_q))
            OP_LB:     begin maj = MAJ_LOAD; f3 = 3'b000; end
            OP_LH:     begin maj = MAJ_LOAD; f3 = 3'b001; end
            OP_LW:     begin maj = MAJ_LOAD; f3 = 3'b010; end
            OP_LBU:    begin maj = MAJ_LOAD; f3 = 3'b100; end
            OP_LHU:    begin maj = MAJ_LOAD; f3 = 3'b101; end
            OP_SB:     begin fmt = T_S; maj = MAJ_STORE; f3 = 3'b000; end
            OP_SH:     begin fmt = T_S; maj = MAJ_STORE; f3 = 3'b001; end
            OP_SW:     begin fmt = T_S; maj = MAJ_STORE; f3 = 3'b010; end
            OP_SLL:    begin fmt = T_R; maj = MAJ_OP; f3 = 3'b001; end
            OP_SLLI:   begin is_shift = 1'b1; f3 = 3'b001; end
            OP_SRL:    begin fmt = T_R; maj = MAJ_OP; f3 = 3'b101; end
            OP_SRLI:   begin is_shift = 1'b1; f3 = 3'b101; end
            OP_SRA:    begin fmt = T_R; maj = MAJ_OP; f3 = 3'b101; f7 = 7'b0100000; end
            OP_SRAI:   begin is_shift = 1'b1; f3 = 3'b101; f7 = 7'b0100000; end
            OP_ADD:    begin fmt = T_R; maj = MAJ_OP; f3 = 3'b000; end
            OP_ADDI:   f3 = 3'b000;
            OP_SUB:    begin fmt = T_R; maj = MAJ_OP; f3 = 3'b000; f7 = 7'b0100000; end
            OP_LUI:    begin fmt = T_U; maj = MAJ_LUI; end
            OP_AUIPC:  begin fmt = T_U; maj = MAJ_AUIPC; end
            OP_XOR:    begin fmt = T_R; maj = MAJ_OP; f3 = 3'b100; end
            OP_XORI:   f3 = 3'b100;
            OP_OR:     begin fmt = T_R; maj = MAJ_OP; f3 = 3'b110; end
            OP_ORI:    f3 = 3'b110;
            OP_AND:    begin fmt = T_R; maj = MAJ_OP; f3 = 3'b111; end
            OP_ANDI:   f3 = 3'b111;
            OP_SLT:    begin fmt = T_R; maj = MAJ_OP; f3 = 3'b010; end
            OP_SLTI:   f3 = 3'b010;
            OP_SLTU:   begin fmt = T_R; maj = MAJ_OP; f3 = 3'b011; end
            OP_SLTIU:  f3 = 3'b011;
            OP_BEQ:    begin fmt = T_B; maj = MAJ_BRANCH; f3 = 3'b000; end
            OP_BNE:    begin fmt = T_B; maj = MAJ_BRANCH; f3 = 3'b001; end
            OP_BLT:    begin fmt = T_B; maj = MAJ_BRANCH; f3 = 3'b100; end
            OP_BGE:    begin fmt = T_B; maj = MAJ_BRANCH; f3 = 3'b101; end
            OP_BLTU:   begin fmt = T_B; maj = MAJ_BRANCH; f3 = 3'b110; end
            OP_BGEU:   begin fmt = T_B; maj = MAJ_BRANCH; f3 = 3'b111; end
            OP_JAL:    begin fmt = T_J; maj = MAJ_JAL; end
            OP_JALR:   begin maj = MAJ_JALR; f3 = 3'b000; end
            OP_FENCE:  begin is_fixed = 1'b1; fixed_word = 32'h0FF0000F; end
            OP_FENCEI: begin is_fixed = 1'b1; fixed_word = 32'h0000100F; end
            OP_CSRRW:  begin is_csr = 1'b1; maj = MAJ_SYSTEM; f3 = 3'b001; end
            OP_CSRRS:  begin is_csr = 1'b1; maj = MAJ_SYSTEM; f3 = 3'b010; end
            OP_CSRRC:  begin is_csr = 1'b1; maj = MAJ_SYSTEM; f3 = 3'b011; end
            OP_CSRRWI: begin is_csr = 1'b1; maj = MAJ_SYSTEM; f3 = 3'b101; end
            OP_CSRRSI: begin is_csr = 1'b1; maj = MAJ_SYSTEM; f3 = 3'b110; end
            OP_CSRRCI: begin is_csr = 1'b1; maj = MAJ_SYSTEM; f3 = 3'b111; end
            OP_ECALL:  begin is_fixed = 1'b1; fixed_word = 32'h00000073; end
            OP_EBREAK: begin is_fixed = 1'b1; fixed_word = 32'h00100073; end
            OP_MRET:   begin is_fixed = 1'b1; fixed_word = 32'h30200073; end
            OP_WFI:    begin is_fixed = 1'b1; fixed_word = 32'h10500073; end
            OP_NOP:    begin is_fixed = 1'b1; fmt = T_NOP; fixed_word = 32'h00000013; end
            default:   begin illegal = 1'b1; fmt = T_BAD; end
        endcase
    end

    // Shifts carry funct7 in the upper immediate bits; CSR ops put the CSR
    // address where an I-type immediate would go.
    always_comb begin
        i_field = s1_imm_q[11:0];
        if (is_shift) begin
            i_field = {f7, s1_imm_q[4:0]};
        end else if (is_csr) begin
            i_field = s1_csr_q[11:0];
        end

        range_bad = 1'b0;
        if (is_fixed || illegal) begin
            range_bad = 1'b0;
        end else if (is_shift) begin
            range_bad = !shamt_ok;
        end else if (is_csr) begin
            range_bad = !csr_ok;
        end else begin
            case (fmt)
                T_I, T_S: range_bad = !fits_i;
                T_B:      range_bad = !fits_b;
                T_U:      range_bad = !u_ok;
                T_J:      range_bad = !fits_j;
                default:  range_bad = 1'b0;
            endcase
        end

        case (fmt)
            T_R:     word = {f7, s1_rs2_q, s1_rs1_q, f3, s1_rd_q, maj};
            T_I:     word = {i_field, s1_rs1_q, f3, s1_rd_q, maj};
            T_S:     word = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, f3, s1_imm_q[4:0], maj};
            T_B:     word = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, f3,
                             s1_imm_q[4:1], s1_imm_q[11], maj};
            T_U:     word = {s1_imm_q[31:12], s1_rd_q, maj};
            T_J:     word = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                             s1_rd_q, maj};
            default: word = '0;
        endcase
        if (is_fixed) begin
            word = fixed_word;
        end
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_opcode_d = s1_opcode_q;
        s1_imm_d    = s1_imm_q;
        s1_csr_d    = s1_csr_q;
        s1_rs1_d    = s1_rs1_q;
        s1_rs2_d    = s1_rs2_q;
        s1_rd_d     = s1_rd_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_opcode_d = in_opcode;
                s1_imm_d    = in_imm;
                s1_csr_d    = in_csr;
                s1_rs1_d    = in_rs1;
                s1_rs2_d    = in_rs2;
                s1_rd_d     = in_rd;
            end
        end

        s2_valid_d = s2_valid_q;
        s2_instr_d = s2_instr_q;
        s2_type_d  = s2_type_q;
        s2_err_d   = s2_err_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_err_d   = illegal || range_bad;
                s2_instr_d = (illegal || range_bad) ? '0 : word;
                s2_type_d  = fmt;
            end
        end

        // A clear in the same cycle as a handshake wins.
        addr_d = addr_q;
        if (addr_clr) begin
            addr_d = '0;
        end else if (out_hs) begin
            addr_d = addr_q + 1'b1;
        end

        err_cnt_d = err_cnt_q;
        if (out_hs && s2_err_q && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_opcode_q <= '0;
            s1_imm_q    <= '0;
            s1_csr_q    <= '0;
            s1_rs1_q    <= '0;
            s1_rs2_q    <= '0;
            s1_rd_q     <= '0;
            s2_valid_q  <= 1'b0;
            s2_instr_q  <= '0;
            s2_type_q   <= '0;
            s2_err_q    <= 1'b0;
            addr_q      <= '0;
            err_cnt_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_opcode_q <= s1_opcode_d;
            s1_imm_q    <= s1_imm_d;
            s1_csr_q    <= s1_csr_d;
            s1_rs1_q    <= s1_rs1_d;
            s1_rs2_q    <= s1_rs2_d;
            s1_rd_q     <= s1_rd_d;
            s2_valid_q  <= s2_valid_d;
            s2_instr_q  <= s2_instr_d;
            s2_type_q   <= s2_type_d;
            s2_err_q    <= s2_err_d;
            addr_q      <= addr_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

endmodule
